serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, minimum 2.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: difference bits produced per cycle; WIDTH SHALL be an integer multiple of it.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to begin one subtraction.
REQ-006 SHALL have port a, input, WIDTH: minuend, sampled when start is accepted.
REQ-007 SHALL have port b, input, WIDTH: subtrahend, sampled when start is accepted.
REQ-008 SHALL have port bin, input, 1: borrow-in, sampled when start is accepted.
REQ-009 SHALL have port busy, output, 1: high while a subtraction is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when the result is valid.
REQ-011 SHALL have port diff, output, WIDTH: result a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout, output, 1: final borrow-out, high when a < b + bin (unsigned).

Function
REQ-013 SHALL use states IDLE, RUN and DONE.
REQ-014 SHALL accept start only when busy is 0, i.e. in IDLE or DONE, and move to RUN on that edge.
REQ-015 SHALL, on acceptance, latch a, b and bin, clear the chunk counter, and load the internal borrow register with bin.
REQ-016 SHALL, on each RUN edge, compute BITS_PER_CYCLE difference bits LSB-first through a rippled borrow chain, seeded from the borrow register.
REQ-017 SHALL, on each RUN edge, store the chunk's final borrow in the borrow register and shift the chunk into the result register.
REQ-018 SHALL take exactly N = WIDTH/BITS_PER_CYCLE RUN edges; after the Nth it SHALL enter DONE with done=1, busy=0, and diff/bout valid.
REQ-019 SHALL hold DONE for one cycle, then go to IDLE, unless start is accepted in DONE, in which case it goes directly to RUN.
REQ-020 SHALL ignore start and all operand inputs while busy=1.
REQ-021 SHALL hold diff and bout stable from DONE until the next completion; partial results SHALL never appear on diff.
REQ-022 SHALL have an accepted-start to done latency of N cycles, giving a throughput of one result per N cycles.

Reset
REQ-023 SHALL, while rst=1, force state to IDLE, with busy=0, done=0, diff=0, bout=0, and the counter and borrow register at 0.
REQ-024 SHALL, when rst asserts mid-RUN, abort the operation with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-025 SHALL, with macro SERIAL_SUB_SIGNED_OVF_EN defined, add output ovf, 1 bit: two's-complement overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-026 SHALL register ovf and update it in the same cycle as diff, with reset value 0.
REQ-027 SHALL, without SERIAL_SUB_SIGNED_OVF_EN, omit port ovf and its logic entirely.

Structure
REQ-028 SHALL take its state encoding type (IDLE/RUN/DONE) from shared package serial_sub_pkg.
REQ-029 SHALL take from serial_sub_pkg a function returning the counter width, clog2(WIDTH/BITS_PER_CYCLE) with a minimum of 1.
REQ-030 SHALL instantiate the 1-bit combinational cell full_subtractor_cell BITS_PER_CYCLE times to form the borrow chain: inputs x, y, bi; outputs d = x^y^bi, bo = (~x&y) | (~(x^y)&bi).

Verification
REQ-031 SHALL cover WIDTH=8, BPC=1, a=0x05, b=0x03, bin=0 -> done 8 cycles after start, diff=0x02, bout=0.
REQ-032 SHALL cover a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1; and a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-033 SHALL cover WIDTH=8, BPC=4, a=0xA7, b=0x29 -> done 2 cycles after start, diff=0x7E, bout=0.
REQ-034 SHALL cover start pulsed with a=0x10, b=0x01 during busy, after an initial start with a=0x05, b=0x03 -> result is 0x02 and exactly one done pulse.
REQ-035 SHALL cover rst asserted at RUN cycle 4 -> busy=0, diff=0, no done; a subsequent start with a=0x09, b=0x04 -> diff=0x05.
REQ-036 SHALL cover, with SERIAL_SUB_SIGNED_OVF_EN, a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0; and back-to-back start in DONE -> next done exactly N cycles later.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the chunk-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Width of the chunk counter: clog2(WIDTH/BITS_PER_CYCLE), never below 1.
  function automatic int cnt_width(input int width, input int bpc);
    int n;
    n = width / bpc;
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit combinational full subtractor: d = x - y - bi, bo = borrow out.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Serial subtractor: computes a - b - bin, BITS_PER_CYCLE bits per clock,
// LSB first, through a chain of full_subtractor_cell instances.
// Optional feature: define SERIAL_SUB_SIGNED_OVF_EN to add the registered
// two's-complement overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t                    state_r;
  logic [WIDTH-1:0]          a_r;
  logic [WIDTH-1:0]          b_r;
  logic [WIDTH-1:0]          res_r;
  logic                      borrow_r;
  logic [CW-1:0]             cnt_r;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic                      a_msb_r;
  logic                      b_msb_r;
`endif

  logic [BITS_PER_CYCLE-1:0] x_s;
  logic [BITS_PER_CYCLE-1:0] y_s;
  logic [BITS_PER_CYCLE-1:0] d_s;
  logic [BITS_PER_CYCLE:0]   chain_s;
  logic [WIDTH-1:0]          d_ext_s;
  logic [WIDTH-1:0]          res_next_s;

  // The low chunk of the operand shift registers feeds the borrow chain,
  // which is seeded from the borrow left by the previous chunk.
  assign x_s        = a_r[BITS_PER_CYCLE-1:0];
  assign y_s        = b_r[BITS_PER_CYCLE-1:0];
  assign chain_s[0] = borrow_r;

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_cell
      full_subtractor_cell u_cell (
        .x  (x_s[gi]),
        .y  (y_s[gi]),
        .bi (chain_s[gi]),
        .d  (d_s[gi]),
        .bo (chain_s[gi+1])
      );
    end
  endgenerate

  // Shift the new chunk in at the top of the result register; after N
  // chunks the first one computed has reached the LSB position.
  always_comb begin
    d_ext_s                       = '0;
    d_ext_s[BITS_PER_CYCLE-1:0]   = d_s;
    res_next_s = (res_r >> BITS_PER_CYCLE) | (d_ext_s << (WIDTH - BITS_PER_CYCLE));
  end

  // Control FSM with datapath registers; diff/bout only change on completion
  // so partial results never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            res_r    <= '0;
            borrow_r <= bin;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
`endif
          end else begin
            busy     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RUN: begin
          a_r      <= a_r >> BITS_PER_CYCLE;
          b_r      <= b_r >> BITS_PER_CYCLE;
          res_r    <= res_next_s;
          borrow_r <= chain_s[BITS_PER_CYCLE];
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= res_next_s;
            bout    <= chain_s[BITS_PER_CYCLE];
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf     <= (a_msb_r != b_msb_r) && (res_next_s[WIDTH-1] != a_msb_r);
`endif
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor. Two instances are
// exercised: WIDTH=8/BPC=1 and WIDTH=8/BPC=4. ovf checks are compiled in
// when SERIAL_SUB_SIGNED_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       start4;
  logic [7:0] a4;
  logic [7:0] b4;
  logic       bin4;
  logic       busy4;
  logic       done4;
  logic [7:0] diff4;
  logic       bout4;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic       ovf;
  logic       ovf4;
`endif

  int vectors;
  int miscompares;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf4)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start pulse on the BPC=1 instance; called at a negedge and
  // returns at the negedge following the accepting edge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles until done on the BPC=1 instance; -1 if it never comes.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (diff !== 8'h00) begin miscompares++; $display("FAIL reset_diff: got %h expected 00", diff); end
    vectors++; if (bout !== 1'b0)  begin miscompares++; $display("FAIL reset_bout: got %b expected 0", bout); end
    vectors++; if (busy4 !== 1'b0 || done4 !== 1'b0 || diff4 !== 8'h00) begin
      miscompares++; $display("FAIL reset_bpc4: got busy=%b done=%b diff=%h expected 0/0/00", busy4, done4, diff4);
    end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    vectors++; if (ovf !== 1'b0)   begin miscompares++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int c;
    start_op(8'h05, 8'h03, 1'b0);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_done(c);
    vectors++; if (c != 8)         begin miscompares++; $display("FAIL basic_latency: got %0d expected 8", c); end
    vectors++; if (diff !== 8'h02) begin miscompares++; $display("FAIL basic_diff: got %h expected 02", diff); end
    vectors++; if (bout !== 1'b0)  begin miscompares++; $display("FAIL basic_bout: got %b expected 0", bout); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    @(negedge clk);
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    vectors++; if (diff !== 8'h02) begin miscompares++; $display("FAIL basic_diff_hold: got %h expected 02", diff); end
  endtask

  task automatic test_back_to_back();
    int c;
    start_op(8'h03, 8'h05, 1'b0);
    wait_done(c);
    vectors++; if (c != 8)         begin miscompares++; $display("FAIL b2b_latency1: got %0d expected 8", c); end
    vectors++; if (diff !== 8'hFE) begin miscompares++; $display("FAIL b2b_diff1: got %h expected fe", diff); end
    vectors++; if (bout !== 1'b1)  begin miscompares++; $display("FAIL b2b_bout1: got %b expected 1", bout); end
    // restart straight from DONE
    start_op(8'h00, 8'h00, 1'b1);
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1/0", busy, done);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++; if (diff !== 8'hFE) begin miscompares++; $display("FAIL b2b_no_partial: got %h expected fe", diff); end
    wait_done(c);
    vectors++; if (c != 6)         begin miscompares++; $display("FAIL b2b_latency2: got %0d expected 6 more (8 total)", c); end
    vectors++; if (diff !== 8'hFF) begin miscompares++; $display("FAIL b2b_diff2: got %h expected ff", diff); end
    vectors++; if (bout !== 1'b1)  begin miscompares++; $display("FAIL b2b_bout2: got %b expected 1", bout); end
    @(negedge clk);
  endtask

  task automatic test_bpc4();
    logic [7:0] av [2];
    logic [7:0] bv [2];
    logic [7:0] dexp [2];
    logic       bexp [2];
    logic       oexp [2];
    int c;
    av[0] = 8'hA7; bv[0] = 8'h29; dexp[0] = 8'h7E; bexp[0] = 1'b0; oexp[0] = 1'b1;
    av[1] = 8'h00; bv[1] = 8'h01; dexp[1] = 8'hFF; bexp[1] = 1'b1; oexp[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a4 = av[i]; b4 = bv[i]; bin4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      c = -1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (done4) begin
          c = k;
          break;
        end
      end
      vectors++; if (c != 2)            begin miscompares++; $display("FAIL bpc4_latency[%0d]: got %0d expected 2", i, c); end
      vectors++; if (diff4 !== dexp[i]) begin miscompares++; $display("FAIL bpc4_diff[%0d]: got %h expected %h", i, diff4, dexp[i]); end
      vectors++; if (bout4 !== bexp[i]) begin miscompares++; $display("FAIL bpc4_bout[%0d]: got %b expected %b", i, bout4, bexp[i]); end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      vectors++; if (ovf4 !== oexp[i])  begin miscompares++; $display("FAIL bpc4_ovf[%0d]: got %b expected %b", i, ovf4, oexp[i]); end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_busy_ignore();
    int ndone;
    int first;
    ndone = 0;
    first = -1;
    start_op(8'h05, 8'h03, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) begin
        a = 8'h10; b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    start = 1'b0;
    vectors++; if (ndone != 1)     begin miscompares++; $display("FAIL busy_done_count: got %0d expected 1", ndone); end
    vectors++; if (first != 8)     begin miscompares++; $display("FAIL busy_latency: got %0d expected 8", first); end
    vectors++; if (diff !== 8'h02) begin miscompares++; $display("FAIL busy_diff: got %h expected 02", diff); end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    vectors++; if (ovf !== 1'b0)   begin miscompares++; $display("FAIL busy_ovf: got %b expected 0", ovf); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int c;
    int ndone;
    ndone = 0;
    start_op(8'h10, 8'h01, 1'b0);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (diff !== 8'h00) begin miscompares++; $display("FAIL midrst_diff: got %h expected 00", diff); end
    vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL midrst_done: got %b expected 0", done); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    vectors++; if (ndone != 0)     begin miscompares++; $display("FAIL midrst_no_done: got %0d pulses expected 0", ndone); end
    start_op(8'h09, 8'h04, 1'b0);
    wait_done(c);
    vectors++; if (c != 8)         begin miscompares++; $display("FAIL midrst_latency: got %0d expected 8", c); end
    vectors++; if (diff !== 8'h05) begin miscompares++; $display("FAIL midrst_diff_after: got %h expected 05", diff); end
    vectors++; if (bout !== 1'b0)  begin miscompares++; $display("FAIL midrst_bout_after: got %b expected 0", bout); end
    @(negedge clk);
  endtask

  task automatic test_signed_ovf();
    int c;
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(c);
    vectors++; if (c != 8)         begin miscompares++; $display("FAIL ovf_latency: got %0d expected 8", c); end
    vectors++; if (diff !== 8'h7F) begin miscompares++; $display("FAIL ovf_diff: got %h expected 7f", diff); end
    vectors++; if (bout !== 1'b0)  begin miscompares++; $display("FAIL ovf_bout: got %b expected 0", bout); end
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    vectors++; if (ovf !== 1'b1)   begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
`endif
    @(negedge clk);
  endtask

  // Test sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = 8'h00;
    b      = 8'h00;
    bin    = 1'b0;
    start4 = 1'b0;
    a4     = 8'h00;
    b4     = 8'h00;
    bin4   = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bpc4();
    test_busy_ignore();
    test_reset_mid_run();
    test_signed_ovf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
